// File: rtl/audio_stream_sequencer.sv
// Audio stream sequencer: plays a preloaded buffer of interleaved samples into a
// downstream block over a valid/ready link and captures the returned results into a
// second buffer. Supports one-shot and looped playback, abort, and a drain timeout.
module audio_stream_sequencer #(
    parameter int SAMPLE_WIDTH  = 24,
    parameter int NUM_CH        = 2,
    parameter int DEPTH         = 1024,
    parameter int DRAIN_TIMEOUT = 4096,
    localparam int AW = (DEPTH * NUM_CH > 1) ? $clog2(DEPTH * NUM_CH) : 1,
    localparam int NW = $clog2(DEPTH + 1),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_we,
    input  logic [AW-1:0]           load_addr,
    input  logic [SAMPLE_WIDTH-1:0] load_data,
    input  logic [NW-1:0]           num_frames,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    loop_mode,
    output logic                    src_valid,
    output logic [SAMPLE_WIDTH-1:0] src_data,
    output logic [CW-1:0]           src_ch,
    output logic                    src_last,
    input  logic                    src_ready,
    input  logic                    snk_valid,
    input  logic [SAMPLE_WIDTH-1:0] snk_data,
    output logic                    snk_ready,
    input  logic [AW-1:0]           rd_addr,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [31:0]             frames_sent
);

    localparam int WW        = AW + 1;
    localparam int TW        = $clog2(DRAIN_TIMEOUT + 1);
    localparam int MEM_WORDS = 1 << AW;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [WW-1:0]           n_words;
    logic                    loop_q;
    logic [AW-1:0]           idx;
    logic [AW-1:0]           wp;
    logic [WW-1:0]           cap_cnt;
    logic [TW-1:0]           drain_timer;

    logic [SAMPLE_WIDTH-1:0] mem_in  [MEM_WORDS];
    logic [SAMPLE_WIDTH-1:0] mem_cap [MEM_WORDS];

    logic [NW-1:0]           n_clamp;
    logic [WW-1:0]           n_words_start;
    logic                    start_go;
    logic                    src_fire;
    logic                    snk_fire;
    logic                    last_word;
    logic                    wp_last;
    logic                    drain_full;
    logic                    drain_expired;
    logic [CW-1:0]           ch_inc;

    // Decode handshakes, run length and boundary conditions
    always_comb begin
        n_clamp       = (num_frames > NW'(DEPTH)) ? NW'(DEPTH) : num_frames;
        n_words_start = WW'(32'(n_clamp) * NUM_CH);
        start_go      = start && !abort && (state == S_IDLE);
        src_fire      = src_valid && src_ready && (state == S_STREAM);
        snk_fire      = snk_valid && snk_ready;
        last_word     = ({1'b0, idx} == (n_words - WW'(1)));
        wp_last       = ({1'b0, wp} == (n_words - WW'(1)));
        drain_full    = (cap_cnt >= n_words);
        drain_expired = (drain_timer == TW'(DRAIN_TIMEOUT - 1));
        ch_inc        = (src_ch == CW'(NUM_CH - 1)) ? '0 : src_ch + CW'(1);
    end

    // Next-state logic; abort outranks every other transition
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_go) begin
                    state_nxt = (n_clamp == '0) ? S_DONE : S_STREAM;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (src_fire && last_word && !loop_q) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (drain_full || drain_expired) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        snk_ready = (state == S_STREAM) || (state == S_DRAIN);
    end

    // Control, source-side output registers, capture pointers and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            n_words     <= '0;
            loop_q      <= 1'b0;
            idx         <= '0;
            wp          <= '0;
            cap_cnt     <= '0;
            drain_timer <= '0;
            src_valid   <= 1'b0;
            src_data    <= '0;
            src_ch      <= '0;
            src_last    <= 1'b0;
            timeout     <= 1'b0;
            frames_sent <= '0;
        end else begin
            state <= state_nxt;

            if (start_go) begin
                n_words     <= n_words_start;
                loop_q      <= loop_mode;
                idx         <= '0;
                wp          <= '0;
                cap_cnt     <= '0;
                drain_timer <= '0;
                timeout     <= 1'b0;
                frames_sent <= '0;
                // First word is fetched here so it is presented on STREAM entry
                src_valid   <= (n_clamp != '0);
                src_data    <= mem_in[0];
                src_ch      <= '0;
                src_last    <= (NUM_CH == 1);
            end else if (state == S_STREAM) begin
                if (abort) begin
                    src_valid <= 1'b0;
                end
                // A handshake in the abort cycle still happened, so it is counted
                if (src_fire) begin
                    if (src_last && (frames_sent != '1)) begin
                        frames_sent <= frames_sent + 32'd1;
                    end
                    if (last_word) begin
                        if (loop_q) begin
                            idx      <= '0;
                            src_data <= mem_in[0];
                            src_ch   <= '0;
                            src_last <= (NUM_CH == 1);
                        end else begin
                            src_valid <= 1'b0;
                        end
                    end else begin
                        // Next word loads in the accept cycle, keeping src_valid gap-free
                        idx      <= idx + AW'(1);
                        src_data <= mem_in[idx + AW'(1)];
                        src_ch   <= ch_inc;
                        src_last <= (ch_inc == CW'(NUM_CH - 1));
                    end
                end
            end else if (state == S_DRAIN) begin
                drain_timer <= drain_timer + TW'(1);
                if (!abort && !drain_full && drain_expired) begin
                    timeout <= 1'b1;
                end
            end

            if (snk_fire) begin
                wp      <= wp_last ? '0 : wp + AW'(1);
                cap_cnt <= cap_cnt + WW'(1);
            end
        end
    end

    // Input buffer write port; contents survive reset
    always_ff @(posedge clk) begin
        if (load_we) begin
            mem_in[load_addr] <= load_data;
        end
    end

    // Capture buffer: write from the sink, registered read with read-before-write
    always_ff @(posedge clk) begin
        if (snk_fire) begin
            mem_cap[wp] <= snk_data;
        end
        rd_data <= mem_cap[rd_addr];
    end

endmodule

// File: doc/audio_stream_sequencer.md
AUDIO_STREAM_SEQUENCER -- requirements
Module: audio_stream_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): SAMPLE_WIDTH, 24, Q1.23 sample width; NUM_CH, 2, interleaved channels per frame; DEPTH, 1024, frames per buffer; DRAIN_TIMEOUT, 4096, cycles allowed for return samples after last send.
REQ-002 SHALL have ports (name, direction, width, meaning), with one clock and an asynchronous, active-high reset:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- load_we  in  1  input-buffer write strobe
- load_addr  in  clog2(DEPTH*NUM_CH)  input-buffer word address
- load_data  in  SAMPLE_WIDTH  signed input sample
- num_frames  in  clog2(DEPTH+1)  frames to play, sampled at start
- start  in  1  begin run (pulse)
- abort  in  1  terminate run (pulse)
- loop_mode  in  1  wrap and replay, sampled at start
- src_valid  out  1  sample to DUT valid
- src_data  out  SAMPLE_WIDTH  sample to DUT
- src_ch  out  clog2(NUM_CH)  channel index of src_data
- src_last  out  1  last channel of frame
- src_ready  in  1  DUT accepts
- snk_valid  in  1  DUT result valid
- snk_data  in  SAMPLE_WIDTH  DUT result
- snk_ready  out  1  sequencer accepts result
- rd_addr  in  clog2(DEPTH*NUM_CH)  capture-buffer read address
- rd_data  out  SAMPLE_WIDTH  capture-buffer data, 1-cycle latency
- busy  out  1  state is not IDLE
- done  out  1  one-cycle completion pulse
- timeout  out  1  sticky, set on drain timeout
- frames_sent  out  32  completed frames sent since start

Function
REQ-003 SHALL implement states IDLE, STREAM, DRAIN, DONE.
REQ-004 IDLE: start SHALL latch N = min(num_frames, DEPTH) and loop_mode, clear pointers, frames_sent and timeout, and enter STREAM; if N = 0, SHALL enter DONE instead.
REQ-005 STREAM: src_valid SHALL assert no later than 2 cycles after entry; the word index SHALL advance only on src_valid && src_ready.
REQ-006 While src_valid && !src_ready, src_data, src_ch and src_last SHALL hold stable.
REQ-007 Words SHALL be sent in address order 0..N*NUM_CH-1; src_ch = index mod NUM_CH; src_last = (src_ch == NUM_CH-1).
REQ-008 Each accepted word with src_last set SHALL increment frames_sent, saturating at 2^32-1.
REQ-009 The DUT SHALL see no bubble: in STREAM, src_valid SHALL remain high across consecutive accepted words.
REQ-010 On acceptance of word N*NUM_CH-1: if loop_mode, the index SHALL wrap to 0 and STREAM continues; otherwise src_valid SHALL deassert the next cycle and the state SHALL go to DRAIN.
REQ-011 snk_ready SHALL be high in STREAM and DRAIN, and low otherwise; each snk_valid && snk_ready SHALL write snk_data at capture pointer wp, then wp increments, wrapping to 0 at N*NUM_CH.
REQ-012 DRAIN SHALL go to DONE when captured count == sent count; if DRAIN_TIMEOUT cycles elapse first, it SHALL set timeout and go to DONE.
REQ-013 DONE SHALL pulse done for exactly one cycle and then return to IDLE.
REQ-014 abort in STREAM or DRAIN SHALL deassert src_valid and snk_ready the next cycle and go to IDLE with no done pulse; abort in IDLE SHALL be ignored.
REQ-015 Simultaneous start and abort SHALL give priority to abort; start while not IDLE SHALL be ignored.
REQ-016 load_we SHALL be honored in any state; a write to the address being prefetched in STREAM is undefined.
REQ-017 Capture-buffer reads SHALL be available in all states; rd_data SHALL reflect a write made in the same cycle only from the following read onward.

Reset
REQ-018 rst SHALL asynchronously force IDLE and set src_valid=0, src_data=0, src_ch=0, src_last=0, snk_ready=0, busy=0, done=0, timeout=0, frames_sent=0 and all pointers to 0; buffer contents are not reset.
REQ-019 rst asserted mid-run SHALL take effect immediately, with no done pulse and no further writes after release until a new start.

Verification
REQ-020 NUM_CH=2, N=4, load 0..7, src_ready=1, DUT echo with latency 3 -> src_data 0..7 with src_ch 0,1 alternating; frames_sent=4; capture[i]=i; one done pulse; timeout=0.
REQ-021 Random src_ready stalls (about 50%) -> src_data stable during every stall; sequence is identical to REQ-020.
REQ-022 loop_mode=1, N=2, abort after 10 accepted words -> output sequence 0,1,2,3,0,1,2,3,0,1; frames_sent=5; src_valid low one cycle after abort; no done pulse.
REQ-023 N=3, DUT returns only 5 of 6 results -> timeout=1 exactly DRAIN_TIMEOUT cycles after the last send, then a done pulse.
REQ-024 num_frames=0 then start -> no src_valid; done pulses within 2 cycles; busy high for 1 cycle at most.
REQ-025 rst asserted during STREAM at word 3 -> all outputs at reset values in the same cycle; a later start replays from word 0.
